imm_extend_queue: RTL and testbench

- Parametrised, pipelined successor to the 13-bit simm13 sign extender in the SPARC datapath.
- Accepts a raw immediate/displacement field plus a format mode from decode and produces an OUT_W-bit operand.
- Supported formats: sign- or zero-extended simm13, word-shifted disp22/disp30 branch and call displacements, and sethi imm22 placement.
- Results are held in a small FIFO with valid/ready handshakes on both sides, so decode and the ALU/PC-adder stage can stall independently.

---
 rtl/imm_extend_queue.sv | 91 +++++++++
 tb/tb_imm_extend_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_queue.sv
// Immediate/displacement extender feeding a small result FIFO.
// Extension happens at push time; the head entry is held in output registers.
module imm_extend_queue #(
  parameter int IN_W  = 30,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_field,
  input  logic [2:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam bit DISP30_OK = (IN_W >= 30);

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic [29:0]      f30;

  logic [OUT_W:0]   mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]    count_next;
  logic             push, pop;

  always_comb begin
    f30      = 30'(in_field);
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_mode)
      3'b000: ext_data = OUT_W'($signed(in_field[12:0]));
      3'b001: ext_data = OUT_W'(in_field[12:0]);
      3'b010: ext_data = OUT_W'($signed(in_field[21:0])) << 2;
      3'b011: begin
        if (DISP30_OK) ext_data = OUT_W'($signed(f30)) << 2;
        else           ext_err  = 1'b1;
      end
      3'b100: ext_data = OUT_W'(in_field[21:0]) << (OUT_W - 22);
      default: ext_err = 1'b1;
    endcase
  end

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign rd_next   = rd_ptr + AW'(pop);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ext_err, ext_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_ptr + AW'(push);
      count  <= count_next;
      // New head is either the entry being written this edge or one already stored.
      if (pop || (push && count == '0)) begin
        if (push && rd_next == wr_ptr)
          {out_err, out_data} <= {ext_err, ext_data};
        else if (count_next != '0)
          {out_err, out_data} <= mem[rd_next];
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_queue.sv
// Directed bench for imm_extend_queue: a default 32-bit/2-deep instance and
// a 64-bit/4-deep instance driven from the same clock and reset.
module tb_imm_extend_queue;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [29:0] in_field;
  logic [2:0]  in_mode;
  logic [31:0] out_data;
  logic [1:0]  count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [29:0] b_in_field;
  logic [2:0]  b_in_mode;
  logic [63:0] b_out_data;
  logic [2:0]  b_count;

  imm_extend_queue #(.IN_W(30), .OUT_W(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_field(in_field), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .count(count));

  imm_extend_queue #(.IN_W(30), .OUT_W(64), .DEPTH(4)) dut64 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_field(b_in_field), .in_mode(b_in_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err), .count(b_count));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [29:0] field;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vt[13];
  logic [63:0] q[$];

  initial begin
    vt[0]  = '{3'b000, 30'h0000_1000, 32'hFFFF_F000, 1'b0};
    vt[1]  = '{3'b000, 30'h0000_0FFF, 32'h0000_0FFF, 1'b0};
    vt[2]  = '{3'b000, 30'h2AAA_A123, 32'h0000_0123, 1'b0};
    vt[3]  = '{3'b001, 30'h0000_1FFF, 32'h0000_1FFF, 1'b0};
    vt[4]  = '{3'b010, 30'h003F_FFFF, 32'hFFFF_FFFC, 1'b0};
    vt[5]  = '{3'b010, 30'h001F_FFFF, 32'h007F_FFFC, 1'b0};
    vt[6]  = '{3'b011, 30'h2000_0000, 32'h8000_0000, 1'b0};
    vt[7]  = '{3'b011, 30'h0000_0001, 32'h0000_0004, 1'b0};
    vt[8]  = '{3'b100, 30'h003F_FFFF, 32'hFFFF_FC00, 1'b0};
    vt[9]  = '{3'b100, 30'h3FC0_0001, 32'h0000_0400, 1'b0};
    vt[10] = '{3'b101, 30'h0000_1234, 32'h0000_0000, 1'b1};
    vt[11] = '{3'b110, 30'h3FFF_FFFF, 32'h0000_0000, 1'b1};
    vt[12] = '{3'b111, 30'h0000_0001, 32'h0000_0000, 1'b1};

    reset = 1'b1;
    in_valid = 0; out_ready = 0; in_field = '0; in_mode = '0;
    b_in_valid = 0; b_out_ready = 0; b_in_field = '0; b_in_mode = '0;
    #12 reset = 1'b0;
    step();

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);

    // Mode table: push one entry, check head, pop it.
    for (int i = 0; i < 13; i++) begin
      in_valid = 1; in_mode = vt[i].mode; in_field = vt[i].field;
      step();
      in_valid = 0; in_field = 30'h1555_5555; in_mode = 3'b000;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].data);
      chk($sformatf("vec%0d_err", i), out_err, vt[i].err);
      out_ready = 1;
      step();
      out_ready = 0;
      chk($sformatf("vec%0d_count", i), count, 0);
    end

    // Fill, refused third push, then drain in order.
    in_valid = 1; in_mode = 3'b001; in_field = 30'h0AA;
    step();
    in_field = 30'h0BB;
    step();
    chk("full_count", count, 2);
    chk("full_in_ready", in_ready, 0);
    in_field = 30'h0CC;
    step();
    chk("refused_count", count, 2);
    chk("refused_head", out_data, 32'h0AA);
    in_field = 30'h0DD; out_ready = 1;
    step();
    chk("full_poppush_count", count, 1);
    chk("full_poppush_in_ready", in_ready, 1);
    chk("full_poppush_head", out_data, 32'h0BB);
    in_valid = 0;
    step();
    chk("drain_count", count, 0);
    chk("drain_valid", out_valid, 0);
    step();
    chk("empty_hold_data", out_data, 32'h0BB);
    chk("empty_hold_count", count, 0);
    out_ready = 0;

    // Streaming at count=1 with simultaneous push and pop.
    in_valid = 1; in_field = 30'h100;
    step();
    chk("stream_start_count", count, 1);
    out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      in_field = 30'h100 + 30'(i * 17);
      step();
      chk($sformatf("stream%0d_count", i), count, 1);
      chk($sformatf("stream%0d_data", i), out_data, 32'h100 + 32'(i * 17));
    end
    in_valid = 0;
    step();
    chk("stream_end_count", count, 0);
    out_ready = 0;

    // Asynchronous reset between edges with a full queue.
    in_valid = 1; in_mode = 3'b000; in_field = 30'h1000;
    step();
    step();
    in_valid = 0;
    chk("pre_areset_count", count, 2);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("areset_count", count, 0);
    chk("areset_valid", out_valid, 0);
    chk("areset_in_ready", in_ready, 1);
    chk("areset_data", out_data, 0);
    #2 reset = 1'b0;
    step();
    step();
    chk("post_areset_valid", out_valid, 0);
    chk("post_areset_count", count, 0);
    in_valid = 1; in_mode = 3'b000; in_field = 30'h0001;
    step();
    in_valid = 0;
    chk("post_areset_push", out_data, 32'h1);
    chk("post_areset_push_count", count, 1);

    // 64-bit, 4-deep instance.
    b_in_valid = 1; b_in_mode = 3'b000; b_in_field = 30'h1000;
    step();
    b_in_mode = 3'b011; b_in_field = 30'h2000_0000;
    step();
    b_in_mode = 3'b100; b_in_field = 30'h3F_FFFF;
    step();
    b_in_mode = 3'b001; b_in_field = 30'h0077;
    step();
    b_in_field = 30'h0088;
    chk("b_full_count", b_count, 4);
    chk("b_full_in_ready", b_in_ready, 0);
    chk("b_head0", b_out_data, 64'hFFFF_FFFF_FFFF_F000);
    b_in_valid = 0; b_out_ready = 1;
    step();
    chk("b_head1", b_out_data, 64'hFFFF_FFFF_8000_0000);
    step();
    chk("b_head2", b_out_data, 64'hFFFF_FC00_0000_0000);
    step();
    chk("b_head3", b_out_data, 64'h77);
    chk("b_count_after3", b_count, 1);
    b_out_ready = 0;
    q.delete();
    q.push_back(64'h77);

    // Mixed traffic against a queue model to exercise pointer wrap.
    b_in_mode = 3'b001;
    for (int c = 0; c < 24; c++) begin
      logic iv, ordy, push_ok, pop_ok;
      logic [29:0] fld;
      iv   = (c < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      ordy = (c < 6) ? 1'b0 : 1'($urandom_range(0, 1));
      fld  = 30'h200 + 30'(c);
      push_ok = iv && (q.size() < 4);
      pop_ok  = ordy && (q.size() > 0);
      b_in_valid = iv; b_out_ready = ordy; b_in_field = fld;
      step();
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(64'(fld));
      chk($sformatf("b_mix%0d_count", c), b_count, 64'(q.size()));
      chk($sformatf("b_mix%0d_valid", c), b_out_valid, 64'(q.size() != 0));
      if (q.size() != 0)
        chk($sformatf("b_mix%0d_data", c), b_out_data, q[0]);
    end
    b_in_valid = 0; b_out_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
